// File: rtl/fma_operand_classify_if.sv
// ---------------------------------------------------------------------------
// fma_operand_classify_if
// Handshake and data bundle for the FMA operand classifier.
//   upstream   : in_valid / in_ready, operands x, y, z, rounding mode frm
//   downstream : out_valid / out_ready, per-operand sign/inf/zero bits and the
//                combined nan/inf/invalid/killprod/rm flags
// The slave modport is the classifier's view; the master modport is the
// producer/consumer pair that surrounds it.
// ---------------------------------------------------------------------------
interface fma_operand_classify_if #(
   parameter int FLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [FLEN-1:0] x;
   logic [FLEN-1:0] y;
   logic [FLEN-1:0] z;
   logic [2:0]      frm;
   logic            out_valid;
   logic            out_ready;
   logic            xsign, ysign, zsign;
   logic            xinf,  yinf,  zinf;
   logic            xzero, yzero, zzero;
   logic            nan, inf, invalid, killprod, rm;

   modport slave (
      input  in_valid, x, y, z, frm, out_ready,
      output in_ready, out_valid,
      output xsign, ysign, zsign, xinf, yinf, zinf, xzero, yzero, zzero,
      output nan, inf, invalid, killprod, rm
   );

   modport master (
      output in_valid, x, y, z, frm, out_ready,
      input  in_ready, out_valid,
      input  xsign, ysign, zsign, xinf, yinf, zinf, xzero, yzero, zzero,
      input  nan, inf, invalid, killprod, rm
   );
endinterface

// File: rtl/fma_operand_classify.sv
// ---------------------------------------------------------------------------
// fma_operand_classify
// Two-stage elastic pipeline that classifies the three FMA operands
// (x*y + z) and produces the special-case flags used by the FMA sign/special
// stage.
//   S1 : registers per-operand sign and raw class bits (inf, nan, snan, zero)
//        plus the round-toward-minus-infinity indication.
//   S2 : registers every output, including the combined nan/inf/invalid/
//        killprod flags derived from the S1 class bits.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high; clears valids and all data registers
//   flush - synchronous kill of both stages; blocks acceptance that cycle
//   io    - slave side of fma_operand_classify_if (handshake + data)
// ---------------------------------------------------------------------------
module fma_operand_classify #(
   parameter int FLEN = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   fma_operand_classify_if.slave   io
);
   localparam int EXP_MSB  = FLEN - 2;   // 62 for binary64
   localparam int FRAC_W   = 52;
   localparam int EXP_LSB  = FRAC_W;

   typedef struct packed {
      logic sign;
      logic inf;
      logic nan;
      logic snan;
      logic zero;
   } opcls_t;

   typedef struct packed {
      logic xsign, ysign, zsign;
      logic xinf,  yinf,  zinf;
      logic xzero, yzero, zzero;
      logic nan, inf, invalid, killprod, rm;
   } res_t;

   // Subnormals have a zero exponent but a nonzero fraction, so they fall
   // out of every class here (not zero, not inf, not nan).
   function automatic opcls_t classify(input logic [FLEN-1:0] v);
      opcls_t c;
      logic   e_ones, e_zero, f_nz;
      e_ones = &v[EXP_MSB:EXP_LSB];
      e_zero = ~|v[EXP_MSB:EXP_LSB];
      f_nz   = |v[FRAC_W-1:0];
      c.sign = v[FLEN-1];
      c.inf  = e_ones & ~f_nz;
      c.nan  = e_ones &  f_nz;
      c.snan = e_ones &  f_nz & ~v[FRAC_W-1];  // quiet bit clear
      c.zero = e_zero & ~f_nz;
      return c;
   endfunction

   logic   s1_v, s2_v;
   logic   s1_adv, s2_adv;
   opcls_t s1_x_q, s1_y_q, s1_z_q;
   opcls_t s1_x_d, s1_y_d, s1_z_d;
   logic   s1_rm_q, s1_rm_d;
   res_t   s2_q, s2_d;

   // Handshake: a stage advances when it is empty or the stage after it
   // advances. Flush forces in_ready low so nothing is accepted that cycle.
   assign s2_adv      = ~s2_v | io.out_ready;
   assign s1_adv      = ~s1_v | s2_adv;
   assign io.in_ready = s1_adv & ~flush;

   // ---------------- S1 next-state ----------------
   always_comb begin
      s1_x_d  = classify(io.x);
      s1_y_d  = classify(io.y);
      s1_z_d  = classify(io.z);
      s1_rm_d = (io.frm == 3'b010);
   end

   // ---------------- S2 next-state (combined flags) ----------------
   always_comb begin
      logic nan_c, prodinv, pinf, invalid_c;
      nan_c     = s1_x_q.nan | s1_y_q.nan | s1_z_q.nan;
      prodinv   = (s1_x_q.inf & s1_y_q.zero) | (s1_x_q.zero & s1_y_q.inf);
      pinf      = (s1_x_q.inf | s1_y_q.inf) & ~s1_x_q.nan & ~s1_y_q.nan & ~prodinv;
      // inf - inf: infinite product added to an opposite-signed infinite addend
      invalid_c = s1_x_q.snan | s1_y_q.snan | s1_z_q.snan | prodinv |
                  (pinf & s1_z_q.inf & ~s1_z_q.nan &
                   (s1_x_q.sign ^ s1_y_q.sign ^ s1_z_q.sign));

      s2_d          = '0;
      s2_d.xsign    = s1_x_q.sign;
      s2_d.ysign    = s1_y_q.sign;
      s2_d.zsign    = s1_z_q.sign;
      s2_d.xinf     = s1_x_q.inf;
      s2_d.yinf     = s1_y_q.inf;
      s2_d.zinf     = s1_z_q.inf;
      s2_d.xzero    = s1_x_q.zero;
      s2_d.yzero    = s1_y_q.zero;
      s2_d.zzero    = s1_z_q.zero;
      s2_d.nan      = nan_c;
      s2_d.invalid  = invalid_c;
      s2_d.inf      = (s1_x_q.inf | s1_y_q.inf | s1_z_q.inf) & ~nan_c & ~invalid_c;
      s2_d.killprod = s1_x_q.zero | s1_y_q.zero;
      s2_d.rm       = s1_rm_q;
   end

   // ---------------- pipeline registers ----------------
   // Flush only kills the valid bits; data left behind is never presented
   // because out_valid is low, and it is overwritten by the next load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v    <= 1'b0;
         s2_v    <= 1'b0;
         s1_x_q  <= '0;
         s1_y_q  <= '0;
         s1_z_q  <= '0;
         s1_rm_q <= 1'b0;
         s2_q    <= '0;
      end else if (flush) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         if (s1_adv) s1_v <= io.in_valid;
         if (s1_adv && io.in_valid) begin
            s1_x_q  <= s1_x_d;
            s1_y_q  <= s1_y_d;
            s1_z_q  <= s1_z_d;
            s1_rm_q <= s1_rm_d;
         end
         if (s2_adv) s2_v <= s1_v;
         if (s2_adv && s1_v) s2_q <= s2_d;
      end
   end

   // ---------------- outputs, straight from S2 ----------------
   assign io.out_valid = s2_v;
   assign io.xsign     = s2_q.xsign;
   assign io.ysign     = s2_q.ysign;
   assign io.zsign     = s2_q.zsign;
   assign io.xinf      = s2_q.xinf;
   assign io.yinf      = s2_q.yinf;
   assign io.zinf      = s2_q.zinf;
   assign io.xzero     = s2_q.xzero;
   assign io.yzero     = s2_q.yzero;
   assign io.zzero     = s2_q.zzero;
   assign io.nan       = s2_q.nan;
   assign io.inf       = s2_q.inf;
   assign io.invalid   = s2_q.invalid;
   assign io.killprod  = s2_q.killprod;
   assign io.rm        = s2_q.rm;
endmodule

// File: tb/tb_fma_operand_classify.sv
// ---------------------------------------------------------------------------
// tb_fma_operand_classify
// Scoreboard bench: every accepted triple pushes its expected 14-bit result
// (computed from IEEE-754 field rules) into a queue; a monitor pops and
// compares whenever the DUT completes an output handshake.
// Result vector order, MSB first:
//   xsign ysign zsign xinf yinf zinf xzero yzero zzero nan inf invalid killprod rm
// ---------------------------------------------------------------------------
module tb_fma_operand_classify;
   localparam int B_XS = 13, B_YS = 12, B_ZS = 11;
   localparam int B_ZZ = 5,  B_NAN = 4, B_INF = 3, B_INV = 2, B_KP = 1, B_RM = 0;

   localparam logic [63:0] P_ONE  = 64'h3FF0000000000000;
   localparam logic [63:0] N_ONE  = 64'hBFF0000000000000;
   localparam logic [63:0] P_INF  = 64'h7FF0000000000000;
   localparam logic [63:0] N_INF  = 64'hFFF0000000000000;
   localparam logic [63:0] S_NAN  = 64'h7FF0000000000001;
   localparam logic [63:0] Q_NAN  = 64'h7FF8000000000000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;

   fma_operand_classify_if #(.FLEN(64)) bus ();

   fma_operand_classify #(.FLEN(64)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .io    (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_pop = 0;
   logic [13:0] sb[$];

   logic [13:0] dut_vec;
   assign dut_vec = {bus.xsign, bus.ysign, bus.zsign, bus.xinf, bus.yinf, bus.zinf,
                     bus.xzero, bus.yzero, bus.zzero, bus.nan, bus.inf, bus.invalid,
                     bus.killprod, bus.rm};

   // Reference model: decode each operand's fields, then apply the FMA
   // special-case rules on the decoded classes.
   function automatic logic [13:0] ref_model(input logic [63:0] a, b, c, input logic [2:0] f);
      logic [63:0] op [3];
      bit s[3], isinf[3], isnan[3], issnan[3], iszero[3];
      bit any_nan, any_snan, prod_bad, prod_inf, bad, res_inf;
      op[0] = a; op[1] = b; op[2] = c;
      for (int i = 0; i < 3; i++) begin
         int unsigned e;
         logic [51:0] fr;
         e         = int'(op[i][62:52]);
         fr        = op[i][51:0];
         s[i]      = op[i][63];
         isinf[i]  = (e == 2047) && (fr == 0);
         isnan[i]  = (e == 2047) && (fr != 0);
         issnan[i] = isnan[i] && (fr < 52'h8000000000000);
         iszero[i] = (e == 0) && (fr == 0);
      end
      any_nan  = isnan[0] || isnan[1] || isnan[2];
      any_snan = issnan[0] || issnan[1] || issnan[2];
      prod_bad = (isinf[0] && iszero[1]) || (iszero[0] && isinf[1]);
      prod_inf = (isinf[0] || isinf[1]) && !isnan[0] && !isnan[1] && !prod_bad;
      bad      = any_snan || prod_bad ||
                 (prod_inf && isinf[2] && ((s[0] != s[1]) != s[2]));
      res_inf  = (isinf[0] || isinf[1] || isinf[2]) && !any_nan && !bad;
      return {s[0], s[1], s[2], isinf[0], isinf[1], isinf[2],
              iszero[0], iszero[1], iszero[2], any_nan, res_inf, bad,
              iszero[0] || iszero[1], f == 3'd2};
   endfunction

   function automatic logic [63:0] rnd_op();
      logic [63:0] r;
      logic        sg;
      logic [10:0] ex;
      r  = {$urandom(), $urandom()};
      sg = r[63];
      ex = 11'($urandom_range(1, 2046));
      case ($urandom_range(0, 5))
         0:       return {sg, 11'h000, 52'h0};
         1:       return {sg, 11'h7FF, 52'h0};
         2:       return {sg, 11'h7FF, 1'b1, r[50:0]};
         3:       return {sg, 11'h7FF, 1'b0, r[50:1], 1'b1};
         4:       return {sg, ex, r[51:0]};
         default: return {sg, 11'h000, r[51:1], 1'b1};
      endcase
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   // Monitor: every completed output handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         n_cmp++;
         n_pop++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL out_unexpected: got %h with no triple outstanding", dut_vec);
         end else begin
            logic [13:0] e;
            e = sb.pop_front();
            if (dut_vec !== e) begin
               n_bad++;
               $display("FAIL out_data: got %h want %h", dut_vec, e);
            end
         end
      end
   end

   // One cycle: sample acceptance at the negedge, then move past the next posedge.
   task automatic step(output bit acc);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) sb.push_back(ref_model(bus.x, bus.y, bus.z, bus.frm));
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] a, b, c, input logic [2:0] f);
      bit acc, done;
      done = 0;
      bus.in_valid = 1'b1; bus.x = a; bus.y = b; bus.z = c; bus.frm = f;
      for (int k = 0; k < 20 && !done; k++) begin
         step(acc);
         if (acc) done = 1;
      end
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      bit acc;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 60 && sb.size() != 0; k++) step(acc);
      check("drain_empty", 64'(sb.size()), 0);
      step(acc);
   endtask

   // Send one triple into an empty pipeline, check the 2-cycle latency and
   // the masked result fields against hand-derived values.
   task automatic directed(input string nm, input logic [63:0] a, b, c,
                           input logic [2:0] f, input logic [13:0] ev, input logic [13:0] m);
      int  n;
      bit  seen;
      bus.out_ready = 1'b1;
      send(a, b, c, f);
      bus.in_valid = 1'b0;
      n = 0; seen = 0;
      for (int k = 1; k <= 8 && !seen; k++) begin
         @(negedge clk);
         if (bus.out_valid) begin seen = 1; n = k; end
         else begin @(posedge clk); #1; end
      end
      check({nm, "_latency"}, 64'(n), 2);
      check({nm, "_fields"}, 64'(dut_vec & m), 64'(ev & m));
      @(posedge clk); #1;
   endtask

   function automatic logic [13:0] bm(input int b);
      return 14'(1 << b);
   endfunction

   logic [63:0] sx[8], sy[8], sz[8];
   logic [2:0]  sf[8];

   initial begin
      bit acc;
      int idx, pops0;
      logic [13:0] held;
      bus.in_valid = 0; bus.x = 0; bus.y = 0; bus.z = 0; bus.frm = 0; bus.out_ready = 0;

      // reset state
      @(negedge clk);
      check("reset_out_valid", 64'(bus.out_valid), 0);
      check("reset_flags", 64'(dut_vec), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_in_ready", 64'(bus.in_ready), 1);
      @(posedge clk); #1;

      // directed corner cases
      directed("one_negone_zero", P_ONE, N_ONE, 64'h0, 3'd0, bm(B_YS) | bm(B_ZZ),
               bm(B_XS)|bm(B_YS)|bm(B_ZZ)|bm(B_KP)|bm(B_NAN)|bm(B_INF)|bm(B_INV));
      directed("inf_times_zero", P_INF, 64'h0, P_ONE, 3'd0, bm(B_INV) | bm(B_KP),
               bm(B_INV)|bm(B_KP)|bm(B_INF));
      directed("inf_minus_inf", P_INF, P_ONE, N_INF, 3'd0, bm(B_INV), bm(B_INV));
      directed("inf_plus_inf", P_INF, P_ONE, P_INF, 3'd0, bm(B_INF), bm(B_INV)|bm(B_INF));
      directed("snan_addend", P_ONE, P_ONE, S_NAN, 3'd0, bm(B_NAN)|bm(B_INV), bm(B_NAN)|bm(B_INV));
      directed("qnan_rdn", P_ONE, P_ONE, Q_NAN, 3'b010, bm(B_NAN)|bm(B_RM),
               bm(B_NAN)|bm(B_INV)|bm(B_INF)|bm(B_RM));

      // 8 back-to-back triples with a 3-cycle downstream stall
      for (int i = 0; i < 8; i++) begin
         sx[i] = rnd_op(); sy[i] = rnd_op(); sz[i] = rnd_op(); sf[i] = 3'($urandom_range(0, 7));
      end
      pops0 = n_pop;
      idx = 0;
      held = '0;
      for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
         bus.out_ready = !(cyc >= 3 && cyc <= 5);
         bus.in_valid  = 1'b1;
         bus.x = sx[idx]; bus.y = sy[idx]; bus.z = sz[idx]; bus.frm = sf[idx];
         @(negedge clk);
         if (cyc == 3) held = dut_vec;
         if (cyc >= 3 && cyc <= 5) begin
            check("stall_in_ready", 64'(bus.in_ready), 0);
            check("stall_out_valid", 64'(bus.out_valid), 1);
            check("stall_hold", 64'(dut_vec), 64'(held));
         end
         if (bus.in_ready) begin
            sb.push_back(ref_model(bus.x, bus.y, bus.z, bus.frm));
            idx++;
         end
         @(posedge clk); #1;
      end
      drain();
      check("stream_count", 64'(n_pop - pops0), 8);

      // randomized traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.x = rnd_op(); bus.y = rnd_op(); bus.z = rnd_op();
         bus.frm = 3'($urandom_range(0, 7));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step(acc);
      end
      drain();

      // flush with both stages full
      bus.out_ready = 1'b0;
      send(rnd_op(), rnd_op(), rnd_op(), 3'd0);
      send(rnd_op(), rnd_op(), rnd_op(), 3'd2);
      flush = 1'b1;
      bus.x = P_ONE; bus.y = P_ONE; bus.z = P_ONE;   // offered during flush, must be dropped
      @(negedge clk);
      check("flush_in_ready", 64'(bus.in_ready), 0);
      @(posedge clk); #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      check("flush_out_valid", 64'(bus.out_valid), 0);
      @(posedge clk); #1;
      pops0 = n_pop;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step(acc);
      check("flush_no_stale", 64'(n_pop - pops0), 0);

      // reset mid-operation with both stages full
      bus.out_ready = 1'b0;
      send(rnd_op(), rnd_op(), rnd_op(), 3'd1);
      send(rnd_op(), rnd_op(), rnd_op(), 3'd2);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      #2;
      check("midreset_out_valid", 64'(bus.out_valid), 0);
      check("midreset_flags", 64'(dut_vec), 0);
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midreset_in_ready", 64'(bus.in_ready), 1);
      @(posedge clk); #1;
      pops0 = n_pop;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step(acc);
      check("midreset_no_stale", 64'(n_pop - pops0), 0);

      // traffic still flows after reset
      directed("post_reset", N_ONE, 64'h0, N_INF, 3'd0,
               bm(B_XS)|bm(B_ZS)|bm(B_KP)|bm(B_INF), bm(B_XS)|bm(B_ZS)|bm(B_KP)|bm(B_INF)|bm(B_INV));
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1);
   end
endmodule

// File: doc/fma_operand_classify.md
FMA_OPERAND_CLASSIFY -- requirements
Module: fma_operand_classify

Interface
REQ-001 The block SHALL have parameter FLEN, default 64, giving the IEEE-754 operand width; only FLEN=64 (11-bit exponent, 52-bit fraction) is required.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous pipeline kill.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand triple is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the triple is accepted this cycle.
REQ-007 The block SHALL have ports x, y and z, input, FLEN bits each: the multiplicands (x, y) and the addend (z).
REQ-008 The block SHALL have port frm, input, 3 bits: RISC-V rounding mode.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the classification is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have ports xsign, ysign and zsign, output, 1 bit each: the operand sign bits.
REQ-012 The block SHALL have ports xinf, yinf and zinf, output, 1 bit each: the operand is infinity.
REQ-013 The block SHALL have ports xzero, yzero and zzero, output, 1 bit each: the operand is +/-0.
REQ-014 The block SHALL have ports nan, inf, invalid, killprod and rm, output, 1 bit each: the combined flags feeding the FMA sign/special stage.

Function
REQ-015 The block SHALL classify each operand as follows (E = bits[62:52], F = bits[51:0]):
- inf: E all ones and F zero.
- nan: E all ones and F nonzero.
- snan: nan and F[51]=0.
- zero: E zero and F zero.
- Subnormals SHALL NOT be classified as zero.
REQ-016 The block SHALL compute nan = xnan|ynan|znan.
REQ-017 The block SHALL compute prodinv = (xinf&yzero)|(xzero&yinf).
REQ-018 The block SHALL compute pinf = (xinf|yinf) & ~xnan & ~ynan & ~prodinv.
REQ-019 The block SHALL compute invalid = any snan | prodinv | (pinf & zinf & ~znan & (xsign^ysign^zsign)).
REQ-020 The block SHALL compute inf = (xinf|yinf|zinf) & ~nan & ~invalid.
REQ-021 The block SHALL compute killprod = xzero|yzero.
REQ-022 The block SHALL compute rm = (frm==3'b010), i.e. round toward minus infinity.
REQ-023 The block SHALL be a two-stage elastic pipeline:
- Stage S1 registers the signs, per-operand raw class bits and rm.
- Stage S2 registers all outputs, including the combined flags from REQ-016..REQ-021.
- Each stage SHALL have its own valid bit (s1_v, s2_v).
REQ-024 The block SHALL drive out_valid = s2_v, with all data outputs driven from S2 registers only (no combinational path from inputs to outputs).
REQ-025 The block SHALL compute s2_adv = ~s2_v | out_ready and s1_adv = ~s1_v | s2_adv, and drive in_ready = s1_adv.
REQ-026 On an accepted input (in_valid & in_ready), S1 SHALL load; if in_valid=0 while s1_adv=1, s1_v SHALL clear.
REQ-027 When s2_adv=1, S2 SHALL load from S1 and s2_v SHALL take s1_v.
REQ-028 When s2_v=1 and out_ready=0, S2 data and s2_v SHALL hold stable.
REQ-029 When S2 is stalled, S1 SHALL also hold if s1_v=1, and in_ready SHALL be 0 only when both stages are full and stalled.
REQ-030 The latency from acceptance to out_valid SHALL be 2 cycles with out_ready held at 1.
REQ-031 The sustained throughput SHALL be 1 triple per cycle.
REQ-032 The block SHALL NOT drop, duplicate or reorder triples, including on simultaneous accept, advance and stall.
REQ-033 On flush=1, s1_v and s2_v SHALL clear at the next edge and any input offered that cycle SHALL be discarded; in_ready SHALL be 0 during flush.
REQ-034 flush SHALL take priority over accept and advance.
REQ-035 Data registers SHALL load only when their stage advances, and held values SHALL never change under a stall.

Reset
REQ-036 While reset=1, s1_v, s2_v and all data registers SHALL clear to 0 asynchronously, so that out_valid=0 and every flag output reads 0.
REQ-037 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight triples, with no output handshake completing afterwards for them.

Verification
REQ-039 The bench SHALL apply x=3FF0000000000000, y=BFF0000000000000, z=0 with out_ready=1 and check that out_valid rises 2 cycles later with xsign=0, ysign=1, zzero=1, killprod=0, nan=0, inf=0, invalid=0.
REQ-040 The bench SHALL apply x=7FF0000000000000, y=0, z=3FF0000000000000 and check invalid=1, killprod=1, inf=0.
REQ-041 The bench SHALL apply x=7FF0000000000000, y=3FF0000000000000, z=FFF0000000000000 and check invalid=1; then z=7FF0000000000000 and check invalid=0 and inf=1.
REQ-042 The bench SHALL apply z=7FF0000000000001 (sNaN) and check nan=1 and invalid=1; then z=7FF8000000000000 (qNaN) and check nan=1, invalid=0 and inf=0, and check rm=1 when frm=010.
REQ-043 The bench SHALL stream 8 back-to-back triples with out_ready=0 for 3 cycles mid-stream and check:
- in_ready falls once S1 and S2 are full.
- The outputs hold during the stall.
- All 8 triples emerge in order with none lost.
REQ-044 The bench SHALL assert flush and then reset, each with both stages full, and check out_valid=0 on the next edge and no stale result afterwards.
